toy_fetch_mem_req: RTL
======================

TOY_FETCH_MEM_REQ -- requirements
Module: toy_fetch_mem_req

Interface
REQ-001 Parameter OST_DEPTH, default 4, outstanding-entry count; power of two; SHALL not exceed 2**MSHR_ENTRY_INDEX_WIDTH.
REQ-002 Parameter ID_W, default ICACHE_REQ_OPCODE_WIDTH+MSHR_ENTRY_INDEX_WIDTH+ROB_ENTRY_ID_WIDTH, memory transaction id width.
REQ-003 clk  in  1  single clock, all flops rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fe_req_vld/fe_req_rdy  in/out  1/1  front-end fetch request handshake.
REQ-006 fe_req_addr, fe_req_opcode, fe_req_rob_id  in  ADDR_WIDTH/ICACHE_REQ_OPCODE_WIDTH/ROB_ENTRY_ID_WIDTH  request payload.
REQ-007 flush  in  1  squash all in-flight fetches.
REQ-008 fetch_mem_req_vld/fetch_mem_req_rdy  out/in  1/1  memory request handshake.
REQ-009 fetch_mem_req_addr, fetch_mem_req_entry_id  out  ADDR_WIDTH/ID_W  request address; id = {opcode, entry index, rob id}, MSB to LSB.
REQ-010 fetch_mem_ack_vld/fetch_mem_ack_rdy  in/out  1/1  memory ack; rdy tied 1.
REQ-011 fetch_mem_ack_data, fetch_mem_ack_entry_id  in  FETCH_DATA_WIDTH/ID_W  returned data and echoed id.
REQ-012 fe_ack_vld/fe_ack_rdy  out/in  1/1  in-order response to front end.
REQ-013 fe_ack_data, fe_ack_addr, fe_ack_opcode, fe_ack_rob_id  out  FETCH_DATA_WIDTH/ADDR_WIDTH/ICACHE_REQ_OPCODE_WIDTH/ROB_ENTRY_ID_WIDTH  response payload.

Function
REQ-014 Entry array SHALL be a ring of OST_DEPTH entries; pointers alloc_ptr, issue_ptr, ret_ptr, each log2(OST_DEPTH)+1 bits with wrap bit.
REQ-015 Entry state SHALL be FREE -> PEND (accepted) -> WAIT (mem handshake) -> DONE (ack received) -> FREE (retired); plus per-entry drop flag.
REQ-016 fe_req_rdy SHALL be 1 iff registered occupancy < OST_DEPTH and flush=0; same-cycle retire SHALL NOT raise rdy.
REQ-017 Accepted request at cycle N SHALL write entry alloc_ptr, state PEND, and present fetch_mem_req_vld no earlier than N+1.
REQ-018 fetch_mem_req_vld SHALL be 1 iff entry issue_ptr is PEND; payload SHALL hold stable while vld=1 and rdy=0; handshake moves entry to WAIT, issue_ptr+1.
REQ-019 Ack SHALL index the entry with the MSHR index field of fetch_mem_ack_entry_id, store data, and set DONE; acks may arrive out of order.
REQ-020 fe_ack_vld SHALL be 1 iff entry ret_ptr is DONE with drop=0 and flush=0; earliest cycle after ack capture (no bypass).
REQ-021 Round trip with 1-cycle memory: accept N, mem req N+1, ack N+2, fe_ack_vld N+3.
REQ-022 Retirement SHALL be strictly in allocation order; handshake frees entry, ret_ptr+1; fe_ack payload stable while vld=1 and rdy=0.
REQ-023 DONE entry with drop=1 at ret_ptr SHALL retire silently, one per cycle, without fe_ack_vld.
REQ-024 Flush SHALL free all PEND entries (alloc_ptr := issue_ptr after any same-cycle issue) and set drop on every WAIT/DONE entry.
REQ-025 Flush with same-cycle mem handshake: issuing entry SHALL become WAIT with drop=1.
REQ-026 Flush with same-cycle ack: entry SHALL become DONE with drop=1.
REQ-027 Flush SHALL suppress fe_ack_vld that cycle; no fe_ack handshake occurs.
REQ-028 Ack to a non-WAIT entry SHALL be ignored and flagged by a simulation assertion.
REQ-029 Empty (occupancy 0): fetch_mem_req_vld=0, fe_ack_vld=0; pointer wrap SHALL use the wrap bit for full/empty.

Reset
REQ-030 On rst_n=0 asynchronously: all entries FREE, drop=0, pointers 0, occupancy 0.
REQ-031 Reset outputs: fe_req_rdy=0 during reset then 1, fetch_mem_req_vld=0, fe_ack_vld=0, all payload outputs 0, fetch_mem_ack_rdy=1.
REQ-032 Reset mid-operation SHALL discard all entries; acks arriving after release for pre-reset ids SHALL be ignored per REQ-028.

Structure
REQ-033 toy_pack SHALL hold FETCH_OST_DEPTH, FETCH_MEM_ID_WIDTH, and enum fetch_ost_state_e {FREE, PEND, WAIT, DONE}.
REQ-034 Single module; no sub-module; entry storage and state flops inline.

Verification
REQ-035 Single req addr 0x100, rob 3, 1-cycle memory -> fe_ack_vld at N+3, addr 0x100, rob 3, correct data.
REQ-036 4 reqs back-to-back, acks returned order 2,0,3,1 -> fe_ack in order 0,1,2,3; fe_req_rdy=0 while 4 outstanding.
REQ-037 fetch_mem_req_rdy=0 for 5 cycles with 2 PEND -> addr/entry_id stable; both issued in order once rdy=1.
REQ-038 Flush with 1 PEND, 2 WAIT -> PEND freed, 0 fe_ack for the 2 WAIT after acks; occupancy reaches 0.
REQ-039 Flush same cycle as ack and as mem handshake -> both entries dropped, no fe_ack, new req after flush returns normally.
REQ-040 rst_n asserted with 3 outstanding -> all outputs reset values same cycle; stale ack after release ignored, assertion fires.

Source files
------------

// File: rtl/toy_pack.sv
// Shared definitions for the instruction-fetch memory request block.
//
// Holds the payload widths seen on the front-end and memory interfaces, the
// default outstanding-entry count, the memory transaction id width and the
// per-entry lifecycle state.
//
// A memory transaction id is {opcode, entry index, rob id}, MSB to LSB.
package toy_pack;

  localparam int ADDR_WIDTH              = 32;
  localparam int ICACHE_REQ_OPCODE_WIDTH = 2;
  localparam int MSHR_ENTRY_INDEX_WIDTH  = 3;
  localparam int ROB_ENTRY_ID_WIDTH      = 5;
  localparam int FETCH_DATA_WIDTH        = 32;

  // Default number of outstanding fetches. It must be a power of two and
  // must fit in the entry index field of the transaction id.
  localparam int FETCH_OST_DEPTH = 4;

  localparam int FETCH_MEM_ID_WIDTH =
    ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH + ROB_ENTRY_ID_WIDTH;

  // FREE: slot unused. PEND: accepted, memory request not yet handed off.
  // WAIT: memory request handed off, ack outstanding. DONE: data captured,
  // waiting for in-order retirement.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_ost_state_e;

endpackage

// File: rtl/toy_fetch_mem_req.sv
// Instruction-fetch memory request tracker.
//
// Accepts fetch requests from the front end, issues them to memory in order,
// accepts memory acks in any order (matched by the entry index carried in the
// transaction id), and returns responses to the front end strictly in
// allocation order. A flush squashes everything in flight: requests not yet
// issued are freed at once, issued ones are marked to be dropped silently
// when their ack comes back.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   fe_req_vld/rdy, fe_req_addr,
//   fe_req_opcode, fe_req_rob_id     front-end request
//   flush                            squash all in-flight fetches
//   fetch_mem_req_vld/rdy,
//   fetch_mem_req_addr/entry_id      memory request
//   fetch_mem_ack_vld/rdy,
//   fetch_mem_ack_data/entry_id      memory ack (rdy tied high)
//   fe_ack_vld/rdy, fe_ack_data,
//   fe_ack_addr/opcode/rob_id        in-order response to the front end
module toy_fetch_mem_req
  import toy_pack::*;
#(
  parameter int OST_DEPTH = FETCH_OST_DEPTH,
  parameter int ID_W      = FETCH_MEM_ID_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,

  input  logic                               fe_req_vld,
  output logic                               fe_req_rdy,
  input  logic [ADDR_WIDTH-1:0]              fe_req_addr,
  input  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] fe_req_opcode,
  input  logic [ROB_ENTRY_ID_WIDTH-1:0]      fe_req_rob_id,

  input  logic                               flush,

  output logic                               fetch_mem_req_vld,
  input  logic                               fetch_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]              fetch_mem_req_addr,
  output logic [ID_W-1:0]                    fetch_mem_req_entry_id,

  input  logic                               fetch_mem_ack_vld,
  output logic                               fetch_mem_ack_rdy,
  input  logic [FETCH_DATA_WIDTH-1:0]        fetch_mem_ack_data,
  input  logic [ID_W-1:0]                    fetch_mem_ack_entry_id,

  output logic                               fe_ack_vld,
  input  logic                               fe_ack_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]        fe_ack_data,
  output logic [ADDR_WIDTH-1:0]              fe_ack_addr,
  output logic [ICACHE_REQ_OPCODE_WIDTH-1:0] fe_ack_opcode,
  output logic [ROB_ENTRY_ID_WIDTH-1:0]      fe_ack_rob_id
);

  localparam int IDX_W  = $clog2(OST_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int OPC_W  = ICACHE_REQ_OPCODE_WIDTH;
  localparam int MSHR_W = MSHR_ENTRY_INDEX_WIDTH;
  localparam int ROB_W  = ROB_ENTRY_ID_WIDTH;

  // Entry state and drop flags (reset) plus payload storage (not reset).
  fetch_ost_state_e state_q [OST_DEPTH];
  fetch_ost_state_e state_d [OST_DEPTH];
  logic [OST_DEPTH-1:0] drop_q, drop_d;

  logic [ADDR_WIDTH-1:0]       addr_q [OST_DEPTH];
  logic [OPC_W-1:0]            opc_q  [OST_DEPTH];
  logic [ROB_W-1:0]            rob_q  [OST_DEPTH];
  logic [FETCH_DATA_WIDTH-1:0] data_q [OST_DEPTH];

  // Ring pointers carry an extra wrap bit so full and empty differ.
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] issue_ptr_q, issue_ptr_d;
  logic [PTR_W-1:0] ret_ptr_q,   ret_ptr_d;

  logic [IDX_W-1:0] alloc_idx, issue_idx, ret_idx, ack_idx;
  assign alloc_idx = alloc_ptr_q[IDX_W-1:0];
  assign issue_idx = issue_ptr_q[IDX_W-1:0];
  assign ret_idx   = ret_ptr_q[IDX_W-1:0];

  // Occupancy comes only from registered pointers, so a retirement in this
  // cycle cannot open the front-end door in the same cycle.
  logic full;
  assign full = (alloc_idx == ret_idx) &&
                (alloc_ptr_q[IDX_W] != ret_ptr_q[IDX_W]);

  // ---------------------------------------------------------------------
  // Memory ack decode: split the echoed id into its fields.
  // ---------------------------------------------------------------------
  logic [OPC_W-1:0]  ack_opc;
  logic [MSHR_W-1:0] ack_mshr;
  logic [ROB_W-1:0]  ack_rob;
  logic              ack_in_range;
  logic              ack_hit;
  logic              ack_bad;

  assign ack_rob      = fetch_mem_ack_entry_id[ROB_W-1:0];
  assign ack_mshr     = fetch_mem_ack_entry_id[ROB_W +: MSHR_W];
  assign ack_opc      = fetch_mem_ack_entry_id[ROB_W + MSHR_W +: OPC_W];
  assign ack_idx      = ack_mshr[IDX_W-1:0];
  assign ack_in_range = {1'b0, ack_mshr} < (MSHR_W + 1)'(OST_DEPTH);

  // An ack is only accepted for an entry that is actually waiting and whose
  // echoed opcode and rob id match what was issued; anything else (stale ids
  // from before a reset, duplicates) is ignored.
  assign ack_hit = fetch_mem_ack_vld && ack_in_range &&
                   (state_q[ack_idx] == WAIT) &&
                   (opc_q[ack_idx] == ack_opc) &&
                   (rob_q[ack_idx] == ack_rob);
  assign ack_bad = fetch_mem_ack_vld && !ack_hit;

  assign fetch_mem_ack_rdy = 1'b1;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  logic fe_fire, mem_fire, ret_fire, drop_retire;

  assign fe_req_rdy        = rst_n && !full && !flush;
  assign fetch_mem_req_vld = (state_q[issue_idx] == PEND);
  assign fe_ack_vld        = (state_q[ret_idx] == DONE) && !drop_q[ret_idx] && !flush;

  assign fe_fire     = fe_req_vld && fe_req_rdy;
  assign mem_fire    = fetch_mem_req_vld && fetch_mem_req_rdy;
  assign ret_fire    = fe_ack_vld && fe_ack_rdy;
  assign drop_retire = (state_q[ret_idx] == DONE) && drop_q[ret_idx];

  // Payloads are forced to zero while their valid is low; they come straight
  // from the entry at the pointer, so they hold while the pointer holds.
  assign fetch_mem_req_addr     = fetch_mem_req_vld ? addr_q[issue_idx] : '0;
  assign fetch_mem_req_entry_id = fetch_mem_req_vld ?
    ID_W'({opc_q[issue_idx], MSHR_W'(issue_idx), rob_q[issue_idx]}) : '0;

  assign fe_ack_data   = fe_ack_vld ? data_q[ret_idx] : '0;
  assign fe_ack_addr   = fe_ack_vld ? addr_q[ret_idx] : '0;
  assign fe_ack_opcode = fe_ack_vld ? opc_q[ret_idx]  : '0;
  assign fe_ack_rob_id = fe_ack_vld ? rob_q[ret_idx]  : '0;

  // ---------------------------------------------------------------------
  // Next-state for entries and pointers. Events touch distinct entries
  // (PEND, WAIT and DONE slots never coincide), so their order only matters
  // for flush, which is applied last to the already-updated states.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    drop_d      = drop_q;
    alloc_ptr_d = alloc_ptr_q;
    issue_ptr_d = issue_ptr_q;
    ret_ptr_d   = ret_ptr_q;

    if (mem_fire) begin
      state_d[issue_idx] = WAIT;
      issue_ptr_d        = issue_ptr_q + PTR_W'(1);
    end

    if (ack_hit) begin
      state_d[ack_idx] = DONE;
    end

    if (ret_fire || drop_retire) begin
      state_d[ret_idx] = FREE;
      drop_d[ret_idx]  = 1'b0;
      ret_ptr_d        = ret_ptr_q + PTR_W'(1);
    end

    if (fe_fire) begin
      state_d[alloc_idx] = PEND;
      drop_d[alloc_idx]  = 1'b0;
      alloc_ptr_d        = alloc_ptr_q + PTR_W'(1);
    end

    // Unissued entries vanish; issued ones stay so their ack can still be
    // absorbed, but they will retire without a front-end response.
    if (flush) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (state_d[i] == PEND) begin
          state_d[i] = FREE;
        end else if (state_d[i] != FREE) begin
          drop_d[i] = 1'b1;
        end
      end
      alloc_ptr_d = issue_ptr_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        state_q[i] <= FREE;
      end
      drop_q      <= '0;
      alloc_ptr_q <= '0;
      issue_ptr_q <= '0;
      ret_ptr_q   <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      alloc_ptr_q <= alloc_ptr_d;
      issue_ptr_q <= issue_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
    end
  end

  // NOTE: payload storage has no reset; it is only ever read through an
  // entry whose state says it was written, and outputs are zeroed otherwise.
  always_ff @(posedge clk) begin
    if (fe_fire) begin
      addr_q[alloc_idx] <= fe_req_addr;
      opc_q[alloc_idx]  <= fe_req_opcode;
      rob_q[alloc_idx]  <= fe_req_rob_id;
    end
    if (ack_hit) begin
      data_q[ack_idx] <= fetch_mem_ack_data;
    end
  end

  // An ack that matches no waiting entry points at a memory-side protocol
  // problem or a stale id from before reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!ack_bad)
        else $warning("toy_fetch_mem_req: ack id %h ignored, no waiting entry",
                      fetch_mem_ack_entry_id);
    end
  end

endmodule
